// File: rtl/pulse_width_decoder_pkg.sv
// Shared types and helpers for the 4-level pulse-width link receiver.
// Holds the FSM state encoding, the error-code values, the lock threshold and the
// width classifier used by pulse_width_decoder and its input synchronizer.
package pulse_width_decoder_pkg;

  // Receiver FSM states.
  typedef enum logic [1:0] {
    ST_START    = 2'd0,  // after reset: discard any pulse already in progress
    ST_IDLE     = 2'd1,  // line low, waiting for a rising edge
    ST_HIGH     = 2'd2,  // measuring a high pulse
    ST_WAIT_LOW = 2'd3   // pulse aborted (too long), wait for the line to drop
  } pw_state_t;

  // Values driven on ERR_CODE.
  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_WIDTH    = 2'b01,
    ERR_OVERFLOW = 2'b10,
    ERR_SEQUENCE = 2'b11
  } pw_err_t;

  // Number of consecutive in-order symbols needed before LOCKED rises.
  localparam int RUN_LOCK = 4;

  // Idle level of the synchronizer flops. Resetting them high means a pin that
  // is already high at reset release never produces a rising edge.
  localparam logic SYNC_RST_VAL = 1'b1;

  // Result of classifying one measured width.
  typedef struct packed {
    logic       hit;  // width lies inside one symbol window
    logic [1:0] sym;  // symbol index when hit=1
  } pw_class_t;

  // Match a width against the four nominal widths base<<k with an inclusive
  // +/- tol window. With sane parameters the windows never overlap; the lowest
  // matching symbol wins if they do.
  function automatic pw_class_t pw_classify(input logic [31:0] w,
                                            input int unsigned base,
                                            input int unsigned tol);
    pw_class_t   r;
    logic [31:0] nom;
    logic [31:0] diff;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      nom  = base << k;
      diff = (w > nom) ? (w - nom) : (nom - w);
      if (!r.hit && (diff <= tol)) begin
        r.hit = 1'b1;
        r.sym = 2'(k);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pulse_width_decoder_sync_edge.sv
// Purpose: bring the asynchronous PIN into the CLK domain and derive edge strobes.
// Latency: s2 follows PIN after 2 CLK edges; rise/fall are valid in the cycle after s2 changes.
// Backpressure: none, free-running sampler.
// Ports:
//   CLK, RST : system clock, synchronous active-high reset (flops reset to 1)
//   pin      : asynchronous input, idle low
//   s2       : synchronized level
//   rise     : one-cycle strobe, s2 went 0->1
//   fall     : one-cycle strobe, s2 went 1->0
module pulse_width_decoder_sync_edge
  import pulse_width_decoder_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic pin,
  output logic s2,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s3;

  // s1/s2 form the metastability guard; s3 is a plain delay of s2 for edge detection.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1 <= SYNC_RST_VAL;
      s2 <= SYNC_RST_VAL;
      s3 <= SYNC_RST_VAL;
    end else begin
      s1 <= pin;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/pulse_width_decoder.sv
// Purpose: measure high pulses on PIN, decode them as symbols 0..3 and check round-robin order.
// Latency: SYM_VALID/ERR strobe on the 3rd CLK edge counting the first edge that samples PIN low.
// Backpressure: none; strobes are one cycle wide and must be consumed when they occur.
// Ports:
//   CLK, RST  : system clock, synchronous active-high reset
//   PIN       : asynchronous pulse input, idle low
//   SYM       : last decoded symbol, held between strobes
//   SYM_VALID : one-cycle strobe per pulse whose width matched a symbol window
//   ERR       : one-cycle error strobe
//   ERR_CODE  : 01 bad width, 10 overflow, 11 out of sequence; held until the next ERR
//   LOCKED    : high after RUN_LOCK consecutive in-order symbols
//   WIDTH     : width in ticks of the last pulse that reached its falling edge
module pulse_width_decoder
  import pulse_width_decoder_pkg::*;
#(
  parameter int TICK_DIV = 16384,  // CLK cycles per measurement tick
  parameter int BASE     = 100,    // nominal width of symbol 0 in ticks
  parameter int TOL      = 10,     // accepted deviation in ticks, inclusive
  parameter int CW       = 12      // width counter bits, must hold (BASE<<3)+TOL+1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          PIN,
  output logic [1:0]    SYM,
  output logic          SYM_VALID,
  output logic          ERR,
  output logic [1:0]    ERR_CODE,
  output logic          LOCKED,
  output logic [CW-1:0] WIDTH
);

  localparam int            PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  // Longest acceptable width: symbol 3 plus tolerance. One tick beyond aborts the pulse.
  localparam logic [CW-1:0] W_LIMIT = CW'((BASE << 3) + TOL);
  localparam logic [CW-1:0] W_MAX   = '1;

  // ---------------------------------------------------------------------------
  // Input synchronizer and edge detection
  // ---------------------------------------------------------------------------
  logic s2;
  logic rise;
  logic fall;

  pulse_width_decoder_sync_edge u_sync (
    .CLK  (CLK),
    .RST  (RST),
    .pin  (PIN),
    .s2   (s2),
    .rise (rise),
    .fall (fall)
  );

  // ---------------------------------------------------------------------------
  // Tick prescaler
  // A rise restarts the prescaler so every pulse is measured from a fresh tick
  // phase; the restart value is used combinationally in the rise cycle itself.
  // ---------------------------------------------------------------------------
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_base;
  logic          tick;

  assign presc_base = rise ? '0 : presc;
  assign tick       = (presc_base == PW'(TICK_DIV - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc_base + PW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Width counter
  // Cleared on rise, counts ticks while the synchronized line is high and
  // saturates at all-ones. Because the rise cycle itself already counts, a pulse
  // of N high CLK cycles yields w = N when TICK_DIV = 1.
  // ---------------------------------------------------------------------------
  logic [CW-1:0] w;
  logic [CW-1:0] w_base;
  logic [CW-1:0] w_next;
  logic          w_inc;

  assign w_base = rise ? '0 : w;
  assign w_inc  = tick & s2 & (w_base != W_MAX);
  assign w_next = w_base + CW'(w_inc);

  always_ff @(posedge CLK) begin
    if (RST) begin
      w <= '0;
    end else begin
      w <= w_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Classifier and sequence bookkeeping (combinational helpers)
  // ---------------------------------------------------------------------------
  pw_class_t  cls;
  logic       overflow;
  logic       hist_vld;   // prev_sym holds a symbol from the current in-order run
  logic [1:0] prev_sym;
  logic [1:0] seq_exp;    // symbol the transmitter should send next
  logic       seq_ok;
  logic [2:0] run;
  logic [2:0] run_next;

  always_comb begin
    cls = pw_classify(32'(w), BASE, TOL);
  end

  // Only meaningful in ST_HIGH; the line cannot both fall and gain a tick in
  // the same cycle, so overflow and fall are mutually exclusive there.
  assign overflow = (w_next > W_LIMIT);

  // 2-bit add wraps 3 -> 0, matching the transmitter's round-robin order.
  assign seq_exp = prev_sym + 2'd1;
  assign seq_ok  = !hist_vld || (cls.sym == seq_exp);

  always_comb begin
    run_next = 3'd1;
    if (hist_vld) begin
      run_next = (run >= 3'(RUN_LOCK)) ? 3'(RUN_LOCK) : run + 3'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM with registered outputs
  // ---------------------------------------------------------------------------
  pw_state_t state;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_START;
      SYM       <= 2'd0;
      SYM_VALID <= 1'b0;
      ERR       <= 1'b0;
      ERR_CODE  <= ERR_NONE;
      LOCKED    <= 1'b0;
      WIDTH     <= '0;
      hist_vld  <= 1'b0;
      prev_sym  <= 2'd0;
      run       <= 3'd0;
    end else begin
      SYM_VALID <= 1'b0;
      ERR       <= 1'b0;

      case (state)
        ST_START: begin
          // A pulse that was already high at reset has no valid start; skip it.
          if (!s2) begin
            state <= ST_IDLE;
          end
        end

        ST_IDLE: begin
          if (rise) begin
            state <= ST_HIGH;
          end
        end

        ST_HIGH: begin
          if (fall) begin
            state <= ST_IDLE;
            WIDTH <= w;
            if (cls.hit) begin
              SYM       <= cls.sym;
              SYM_VALID <= 1'b1;
              hist_vld  <= 1'b1;
              prev_sym  <= cls.sym;
              if (seq_ok) begin
                run    <= run_next;
                LOCKED <= (run_next == 3'(RUN_LOCK));
              end else begin
                // Out-of-order symbol still counts as the start of a new run.
                ERR      <= 1'b1;
                ERR_CODE <= ERR_SEQUENCE;
                LOCKED   <= 1'b0;
                run      <= 3'd1;
              end
            end else begin
              ERR      <= 1'b1;
              ERR_CODE <= ERR_WIDTH;
              LOCKED   <= 1'b0;
              hist_vld <= 1'b0;
              run      <= 3'd0;
            end
          end else if (overflow) begin
            state    <= ST_WAIT_LOW;
            ERR      <= 1'b1;
            ERR_CODE <= ERR_OVERFLOW;
            LOCKED   <= 1'b0;
            hist_vld <= 1'b0;
            run      <= 3'd0;
          end
        end

        ST_WAIT_LOW: begin
          if (!s2) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_START;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_width_decoder.sv
// Bench for pulse_width_decoder with TICK_DIV=1: drives pulses of known length,
// logs every strobe cycle, and compares against events predicted from the
// symbol windows, overflow limit and round-robin order.
module tb_pulse_width_decoder;

  localparam int BASE  = 100;
  localparam int TOL   = 10;
  localparam int CW    = 12;
  localparam int LIMIT = (BASE << 3) + TOL;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          PIN = 1'b0;
  logic [1:0]    SYM;
  logic          SYM_VALID;
  logic          ERR;
  logic [1:0]    ERR_CODE;
  logic          LOCKED;
  logic [CW-1:0] WIDTH;

  pulse_width_decoder #(
    .TICK_DIV (1),
    .BASE     (BASE),
    .TOL      (TOL),
    .CW       (CW)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .PIN       (PIN),
    .SYM       (SYM),
    .SYM_VALID (SYM_VALID),
    .ERR       (ERR),
    .ERR_CODE  (ERR_CODE),
    .LOCKED    (LOCKED),
    .WIDTH     (WIDTH)
  );

  always #5 CLK = ~CLK;

  // Edge index: value after a posedge identifies that edge.
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct packed {
    int            cyc;
    logic          vld;
    logic [1:0]    sym;
    logic          err;
    logic [1:0]    code;
    logic          locked;
    logic [CW-1:0] width;
  } ev_t;

  ev_t obs_q[$];
  ev_t exp_q[$];
  ev_t mon_e;

  // Record every cycle with a strobe, stamped with the edge that produced it.
  always @(negedge CLK) begin
    if (SYM_VALID || ERR) begin
      mon_e.cyc    = cyc;
      mon_e.vld    = SYM_VALID;
      mon_e.sym    = SYM;
      mon_e.err    = ERR;
      mon_e.code   = ERR_CODE;
      mon_e.locked = LOCKED;
      mon_e.width  = WIDTH;
      obs_q.push_back(mon_e);
    end
  end

  int checks = 0;
  int errors = 0;

  // Reference model: held output values plus the current in-order symbol chain.
  logic [1:0]    m_sym;
  logic [1:0]    m_code;
  logic          m_locked;
  logic [CW-1:0] m_width;
  int            chain[$];

  task automatic model_reset();
    m_sym    = 2'd0;
    m_code   = 2'd0;
    m_locked = 1'b0;
    m_width  = '0;
    chain.delete();
  endtask

  // Predict the strobe produced by a pulse of n high cycles whose first high
  // sample was edge first_edge and first low sample was edge low_edge.
  task automatic model_pulse(input int n, input int first_edge, input int low_edge);
    ev_t e;
    int  k;
    int  nom;
    int  diff;
    e = '0;
    if (n > LIMIT) begin
      // Counter reaches LIMIT+1 on the (LIMIT+3)-th edge of the high phase.
      e.cyc = first_edge + LIMIT + 2;
      e.err = 1'b1;
      m_code = 2'b10;
      m_locked = 1'b0;
      chain.delete();
    end else begin
      k = -1;
      for (int j = 0; j < 4; j++) begin
        nom  = BASE << j;
        diff = (n > nom) ? n - nom : nom - n;
        if (diff <= TOL) k = j;
      end
      e.cyc   = low_edge + 2;
      m_width = CW'(n);
      if (k < 0) begin
        e.err    = 1'b1;
        m_code   = 2'b01;
        m_locked = 1'b0;
        chain.delete();
      end else begin
        e.vld = 1'b1;
        m_sym = 2'(k);
        if (chain.size() > 0 && k != (chain[chain.size()-1] + 1) % 4) begin
          e.err  = 1'b1;
          m_code = 2'b11;
          chain.delete();
        end
        chain.push_back(k);
        m_locked = (chain.size() >= 4);
      end
    end
    e.sym    = m_sym;
    e.code   = m_code;
    e.locked = m_locked;
    e.width  = m_width;
    exp_q.push_back(e);
  endtask

  task automatic send_pulse(input int n, input int gap);
    int first_edge = 0;
    int low_edge   = 0;
    for (int i = 0; i < n; i++) begin
      PIN = 1'b1;
      @(posedge CLK); #1;
      if (i == 0) first_edge = cyc;
    end
    for (int j = 0; j < gap; j++) begin
      PIN = 1'b0;
      @(posedge CLK); #1;
      if (j == 0) low_edge = cyc;
    end
    model_pulse(n, first_edge, low_edge);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    PIN = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    model_reset();
    checks++; if (SYM !== m_sym)       begin errors++; $display("FAIL reset_sym: got %0d want %0d", SYM, m_sym); end
    checks++; if (SYM_VALID !== 1'b0)  begin errors++; $display("FAIL reset_sym_valid: got %b want 0", SYM_VALID); end
    checks++; if (ERR !== 1'b0)        begin errors++; $display("FAIL reset_err: got %b want 0", ERR); end
    checks++; if (ERR_CODE !== m_code) begin errors++; $display("FAIL reset_err_code: got %b want %b", ERR_CODE, m_code); end
    checks++; if (LOCKED !== 1'b0)     begin errors++; $display("FAIL reset_locked: got %b want 0", LOCKED); end
    checks++; if (WIDTH !== m_width)   begin errors++; $display("FAIL reset_width: got %0d want %0d", WIDTH, m_width); end
    RST = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
  endtask

  task automatic test_symbols();
    int w[4] = '{100, 200, 400, 800};
    obs_q.delete(); exp_q.delete();
    foreach (w[i]) send_pulse(w[i], 50);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL symbols_count: got %0d events want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL symbols_ev%0d: got %p want %p", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_tolerance();
    int w[10] = '{90, 110, 89, 111, 190, 210, 189, 790, 810, 50};
    obs_q.delete(); exp_q.delete();
    foreach (w[i]) send_pulse(w[i], 50);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL tolerance_count: got %0d events want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL tolerance_ev%0d: got %p want %p", i, obs_q[i], exp_q[i]); end
    end
    // Between strobes the last symbol, code and width stay on the outputs.
    checks++; if (ERR_CODE !== m_code) begin errors++; $display("FAIL tolerance_code_held: got %b want %b", ERR_CODE, m_code); end
    checks++; if (SYM !== m_sym)       begin errors++; $display("FAIL tolerance_sym_held: got %0d want %0d", SYM, m_sym); end
    checks++; if (WIDTH !== m_width)   begin errors++; $display("FAIL tolerance_width_held: got %0d want %0d", WIDTH, m_width); end
  endtask

  task automatic test_overflow();
    obs_q.delete(); exp_q.delete();
    send_pulse(100, 50);
    send_pulse(900, 50);
    send_pulse(100, 50);
    send_pulse(LIMIT + 1, 50);
    send_pulse(200, 50);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL overflow_count: got %0d events want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL overflow_ev%0d: got %p want %p", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_sequence();
    int w[10] = '{60, 100, 200, 400, 800, 400, 800, 100, 200, 400};
    obs_q.delete(); exp_q.delete();
    foreach (w[i]) send_pulse(w[i], 50);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL sequence_count: got %0d events want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL sequence_ev%0d: got %p want %p", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_start_high();
    obs_q.delete(); exp_q.delete();
    PIN = 1'b1;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    model_reset();
    repeat (300) @(posedge CLK);
    #1;
    PIN = 1'b0;
    repeat (50) @(posedge CLK);
    #1;
    send_pulse(200, 50);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL start_high_count: got %0d events want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL start_high_ev%0d: got %p want %p", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_pulse();
    int w[4] = '{400, 800, 100, 200};
    obs_q.delete(); exp_q.delete();
    foreach (w[i]) send_pulse(w[i], 50);
    checks++; if (LOCKED !== m_locked) begin errors++; $display("FAIL midrst_locked_before: got %b want %b", LOCKED, m_locked); end
    // High for 152 edges: the counter holds 150 when RST is sampled.
    PIN = 1'b1;
    repeat (152) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    model_reset();
    checks++; if (SYM !== m_sym)       begin errors++; $display("FAIL midrst_sym: got %0d want %0d", SYM, m_sym); end
    checks++; if (ERR_CODE !== m_code) begin errors++; $display("FAIL midrst_err_code: got %b want %b", ERR_CODE, m_code); end
    checks++; if (LOCKED !== m_locked) begin errors++; $display("FAIL midrst_locked: got %b want %b", LOCKED, m_locked); end
    checks++; if (WIDTH !== m_width)   begin errors++; $display("FAIL midrst_width: got %0d want %0d", WIDTH, m_width); end
    repeat (100) @(posedge CLK);
    #1;
    PIN = 1'b0;
    repeat (50) @(posedge CLK);
    #1;
    checks++;
    if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL midrst_count: got %0d events want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL midrst_ev%0d: got %p want %p", i, obs_q[i], exp_q[i]); end
    end
  endtask

  // Random widths around the symbol windows, the overflow limit and arbitrary
  // values, with gaps down to one cycle so a rise follows a fall immediately.
  task automatic test_random();
    int sel;
    int k;
    int n;
    obs_q.delete(); exp_q.delete();
    for (int p = 0; p < 40; p++) begin
      sel = int'($urandom_range(0, 9));
      if (chain.size() > 0 && (sel < 3 || sel == 9)) k = (chain[chain.size()-1] + 1) % 4;
      else k = int'($urandom_range(0, 3));
      if (sel <= 5)      n = (BASE << k) + int'($urandom_range(0, 24)) - 12;
      else if (sel <= 7) n = int'($urandom_range(20, 800));
      else if (sel == 8) n = int'($urandom_range(LIMIT - 5, LIMIT + 20));
      else               n = BASE << k;
      send_pulse(n, int'($urandom_range(1, 30)));
    end
    repeat (5) @(posedge CLK);
    #1;
    checks++;
    if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL random_count: got %0d events want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL random_ev%0d: got %p want %p", i, obs_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_symbols();
    test_tolerance();
    test_overflow();
    test_sequence();
    test_start_high();
    test_reset_mid_pulse();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
